// File: rtl/count_step_checker.sv
// Step checker for a 4-bit up/down counter sharing this clock. It predicts
// each next counter value from the previous value and direction, flags bad
// steps and counts wrap events and fault entries.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | checking disabled; waiting for en
// SYNC  | one cycle to capture a valid previous value; no checks
// TRACK | every step checked; a bad step raises step_err and enters FAULT
// FAULT | recovering; needs two consecutive good steps to return to TRACK
module count_step_checker (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    input  logic       M,
    input  logic [3:0] Q,
    output logic       wrap_up,
    output logic       wrap_dn,
    output logic       step_err,
    output logic       err_sticky,
    output logic [7:0] wrap_cnt,
    output logic [7:0] err_cnt,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        TRACK = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] q_prev_q, q_prev_d;
    logic       m_prev_q, m_prev_d;
    logic [1:0] good_cnt_q, good_cnt_d;
    logic       wrap_up_q, wrap_up_d;
    logic       wrap_dn_q, wrap_dn_d;
    logic       step_err_q, step_err_d;
    logic       err_sticky_q, err_sticky_d;
    logic [7:0] wrap_cnt_q, wrap_cnt_d;
    logic [7:0] err_cnt_q, err_cnt_d;

    logic [3:0] exp_val;
    logic       good_step;
    logic       hit_wrap_up;
    logic       hit_wrap_dn;

    // Step prediction from the value and direction seen one edge earlier.
    always_comb begin
        exp_val     = m_prev_q ? (q_prev_q + 4'd1) : (q_prev_q - 4'd1);
        good_step   = (Q == exp_val);
        hit_wrap_up = good_step &&  m_prev_q && (q_prev_q == 4'hF) && (Q == 4'h0);
        hit_wrap_dn = good_step && !m_prev_q && (q_prev_q == 4'h0) && (Q == 4'hF);
    end

    // Next-state, pulse and statistics computation.
    always_comb begin
        state_d      = state_q;
        q_prev_d     = Q;
        m_prev_d     = M;
        good_cnt_d   = good_cnt_q;
        wrap_up_d    = 1'b0;
        wrap_dn_d    = 1'b0;
        step_err_d   = 1'b0;
        err_sticky_d = err_sticky_q;
        wrap_cnt_d   = wrap_cnt_q;
        err_cnt_d    = err_cnt_q;

        if (!en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:  state_d = SYNC;
                SYNC:  state_d = TRACK;
                TRACK, FAULT: begin
                    wrap_up_d = hit_wrap_up;
                    wrap_dn_d = hit_wrap_dn;
                    if (hit_wrap_up || hit_wrap_dn) begin
                        wrap_cnt_d = wrap_cnt_q + 8'd1;
                    end
                    if (state_q == TRACK) begin
                        if (!good_step) begin
                            state_d      = FAULT;
                            good_cnt_d   = 2'd0;
                            step_err_d   = 1'b1;
                            err_sticky_d = 1'b1;
                            if (err_cnt_q != 8'hFF) begin
                                err_cnt_d = err_cnt_q + 8'd1;
                            end
                        end
                    end else begin
                        if (!good_step) begin
                            good_cnt_d = 2'd0;
                        end else if (good_cnt_q == 2'd1) begin
                            good_cnt_d = 2'd0;
                            state_d    = TRACK;
                        end else begin
                            good_cnt_d = good_cnt_q + 2'd1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Clear wins over any increment or set on the same edge.
        if (clr) begin
            err_sticky_d = 1'b0;
            wrap_cnt_d   = 8'd0;
            err_cnt_d    = 8'd0;
        end
    end

    // Registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            q_prev_q     <= 4'd0;
            m_prev_q     <= 1'b0;
            good_cnt_q   <= 2'd0;
            wrap_up_q    <= 1'b0;
            wrap_dn_q    <= 1'b0;
            step_err_q   <= 1'b0;
            err_sticky_q <= 1'b0;
            wrap_cnt_q   <= 8'd0;
            err_cnt_q    <= 8'd0;
        end else begin
            state_q      <= state_d;
            q_prev_q     <= q_prev_d;
            m_prev_q     <= m_prev_d;
            good_cnt_q   <= good_cnt_d;
            wrap_up_q    <= wrap_up_d;
            wrap_dn_q    <= wrap_dn_d;
            step_err_q   <= step_err_d;
            err_sticky_q <= err_sticky_d;
            wrap_cnt_q   <= wrap_cnt_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign wrap_up    = wrap_up_q;
    assign wrap_dn    = wrap_dn_q;
    assign step_err   = step_err_q;
    assign err_sticky = err_sticky_q;
    assign wrap_cnt   = wrap_cnt_q;
    assign err_cnt    = err_cnt_q;
    assign state      = state_q;

endmodule

// File: tb/tb_count_step_checker.sv
// Bench for count_step_checker: directed scenarios followed by random
// traffic, checked through a scoreboard fed by a behavioural model.
module tb_count_step_checker;

    logic       clk = 1'b0;
    logic       rst, en, clr, M;
    logic [3:0] Q;
    logic       wrap_up, wrap_dn, step_err, err_sticky;
    logic [7:0] wrap_cnt, err_cnt;
    logic [1:0] state;

    count_step_checker dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .clr        (clr),
        .M          (M),
        .Q          (Q),
        .wrap_up    (wrap_up),
        .wrap_dn    (wrap_dn),
        .step_err   (step_err),
        .err_sticky (err_sticky),
        .wrap_cnt   (wrap_cnt),
        .err_cnt    (err_cnt),
        .state      (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st;
        int wu;
        int wd;
        int se;
        int sticky;
        int wc;
        int ec;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Reference model: mode 0 idle, 1 sync, 2 track, 3 fault.
    int mdl_mode = 0, mdl_qp = 0, mdl_mp = 0, mdl_run = 0;
    int mdl_wc = 0, mdl_ec = 0, mdl_sticky = 0;
    int cnt = 0;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Drive one cycle of inputs and push the expected post-edge outputs.
    task automatic tick(input bit r, input bit e, input bit c, input bit m, input int q);
        exp_t x;
        int   pred;
        bool_t: begin end
        @(negedge clk);
        rst = r; en = e; clr = c; M = m; Q = q[3:0];
        x.wu = 0; x.wd = 0; x.se = 0;
        if (!r) begin
            mdl_mode = 0; mdl_qp = 0; mdl_mp = 0; mdl_run = 0;
            mdl_wc = 0; mdl_ec = 0; mdl_sticky = 0;
        end else begin
            pred = mdl_mp ? (mdl_qp + 1) % 16 : (mdl_qp + 15) % 16;
            if (!e) begin
                mdl_mode = 0;
            end else if (mdl_mode == 0) begin
                mdl_mode = 1;
            end else if (mdl_mode == 1) begin
                mdl_mode = 2;
            end else begin
                if (q == pred && mdl_mp == 1 && mdl_qp == 15) x.wu = 1;
                if (q == pred && mdl_mp == 0 && mdl_qp == 0)  x.wd = 1;
                if (x.wu || x.wd) mdl_wc = (mdl_wc + 1) % 256;
                if (mdl_mode == 2) begin
                    if (q != pred) begin
                        mdl_mode = 3; mdl_run = 0; x.se = 1; mdl_sticky = 1;
                        mdl_ec = (mdl_ec < 255) ? mdl_ec + 1 : 255;
                    end
                end else begin
                    mdl_run = (q == pred) ? mdl_run + 1 : 0;
                    if (mdl_run >= 2) begin
                        mdl_mode = 2; mdl_run = 0;
                    end
                end
            end
            if (c) begin
                mdl_wc = 0; mdl_ec = 0; mdl_sticky = 0;
            end
            mdl_qp = q; mdl_mp = m;
        end
        x.st = mdl_mode; x.sticky = mdl_sticky; x.wc = mdl_wc; x.ec = mdl_ec;
        sb.push_back(x);
    endtask

    // Counter behaving correctly: present cnt, then step by the direction driven.
    task automatic step(input bit c, input bit m);
        tick(1'b1, 1'b1, c, m, cnt);
        cnt = m ? (cnt + 1) % 16 : (cnt + 15) % 16;
    endtask

    // Present a wrong value, after which the counter continues from it.
    task automatic bad(input bit m);
        int q;
        q = (cnt + 5) % 16;
        tick(1'b1, 1'b1, 1'b0, m, q);
        cnt = m ? (q + 1) % 16 : (q + 15) % 16;
    endtask

    // Monitor: compare DUT outputs against the scoreboard after every edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                chk("state",      int'(state),      mon_e.st);
                chk("wrap_up",    int'(wrap_up),    mon_e.wu);
                chk("wrap_dn",    int'(wrap_dn),    mon_e.wd);
                chk("step_err",   int'(step_err),   mon_e.se);
                chk("err_sticky", int'(err_sticky), mon_e.sticky);
                chk("wrap_cnt",   int'(wrap_cnt),   mon_e.wc);
                chk("err_cnt",    int'(err_cnt),    mon_e.ec);
            end
        end
    end

    initial begin
        bit m_cur;
        int q;
        rst = 1'b0; en = 1'b0; clr = 1'b0; M = 1'b0; Q = 4'd0;

        // Reset then count up through a wrap.
        tick(1'b0, 1'b1, 1'b0, 1'b1, 0);
        tick(1'b0, 1'b1, 1'b0, 1'b1, 0);
        cnt = 0;
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1);

        // Reverse and count down through a wrap.
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0);

        // Jump 5 -> 9 in TRACK, then recover.
        for (int i = 0; i < 40 && cnt != 5; i++) step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b0, 1'b1, 9);
        cnt = 10;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1);

        // FAULT recovery: bad, bad, good, bad, good, good.
        bad(1'b1); bad(1'b1); step(1'b0, 1'b1); bad(1'b1);
        step(1'b0, 1'b1); step(1'b0, 1'b1); step(1'b0, 1'b1);

        // Direction change at 7, then a stall.
        for (int i = 0; i < 40 && cnt != 7; i++) step(1'b0, 1'b1);
        step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 6);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 6);
        cnt = 5;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0);

        // Clear on the same edge as an up wrap.
        for (int i = 0; i < 40 && cnt != 15; i++) step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);

        // Saturate err_cnt with repeated fault bursts.
        for (int i = 0; i < 258; i++) begin
            bad(1'b1); step(1'b0, 1'b1); step(1'b0, 1'b1);
        end

        // en low holds statistics; reset mid-FAULT.
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 1'b1, cnt);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
        bad(1'b1);
        tick(1'b0, 1'b1, 1'b0, 1'b1, cnt);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1);

        // Random traffic.
        m_cur = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) m_cur = ~m_cur;
            q = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 15)) : cnt;
            tick(($urandom_range(0, 99) != 0), ($urandom_range(0, 19) != 0),
                 ($urandom_range(0, 29) == 0), m_cur, q);
            cnt = m_cur ? (q + 1) % 16 : (q + 15) % 16;
        end

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_drain", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
